// File: rtl/banner_scroll_ctrl.sv
// Banner scroll sequencer: on each frame request it reads every glyph ROM row and
// hands a WIN_W-column window at the current scroll offset to the framebuffer writer.
module banner_scroll_ctrl #(
   parameter int ROWS       = 15,
   parameter int BANNER_W   = 71,
   parameter int WIN_W      = 16,
   parameter int SCROLL_DIV = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                enable,
   input  logic                frame_tick,
   output logic [4:0]          rom_address,
   input  logic [BANNER_W-1:0] rom_data,
   output logic                row_valid,
   input  logic                row_ready,
   output logic [4:0]          row_index,
   output logic [WIN_W-1:0]    row_pixels,
   output logic [6:0]          scroll_offset,
   output logic                busy,
   output logic                frame_done,
   output logic                overrun
);

   localparam int TICK_W = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      CAPTURE = 2'd2,
      PRESENT = 2'd3
   } state_t;

   state_t              state_r;
   logic                pending_r;
   logic                step_pending_r;
   logic [TICK_W-1:0]   tick_cnt_r;
   logic [4:0]          row_r;

   logic                request_s;
   logic                consume_s;
   logic                tick_wrap_s;

   // Doubling the word makes the wrap-around window a plain left shift.
   function automatic logic [WIN_W-1:0] window_of(input logic [BANNER_W-1:0] data,
                                                  input logic [6:0]          offset);
      logic [2*BANNER_W-1:0] doubled;
      doubled = {data, data} << offset;
      return doubled[2*BANNER_W-1 -: WIN_W];
   endfunction

   assign request_s   = enable & frame_tick;
   assign consume_s   = (state_r == IDLE) & pending_r;
   assign tick_wrap_s = (tick_cnt_r == TICK_W'(SCROLL_DIV - 1));

   // Request bookkeeping, scroll stepping and the row sequencing FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r        <= IDLE;
         pending_r      <= 1'b0;
         step_pending_r <= 1'b0;
         tick_cnt_r     <= '0;
         row_r          <= 5'd0;
         rom_address    <= 5'd0;
         row_valid      <= 1'b0;
         row_index      <= 5'd0;
         row_pixels     <= '0;
         scroll_offset  <= 7'd0;
         busy           <= 1'b0;
         frame_done     <= 1'b0;
         overrun        <= 1'b0;
      end else begin
         frame_done <= 1'b0;

         case (state_r)
            IDLE: begin
               if (pending_r) begin
                  if (step_pending_r) begin
                     scroll_offset <= (scroll_offset == 7'(BANNER_W - 1)) ? 7'd0
                                                                           : scroll_offset + 7'd1;
                  end
                  step_pending_r <= 1'b0;
                  row_r          <= 5'd0;
                  rom_address    <= 5'd0;
                  busy           <= 1'b1;
                  state_r        <= FETCH;
               end else begin
                  busy <= 1'b0;
               end
            end
            FETCH: begin
               state_r <= CAPTURE;
            end
            CAPTURE: begin
               row_pixels <= window_of(rom_data, scroll_offset);
               row_index  <= row_r;
               row_valid  <= 1'b1;
               state_r    <= PRESENT;
            end
            PRESENT: begin
               if (row_valid && row_ready) begin
                  row_valid <= 1'b0;
                  if (row_r == 5'(ROWS - 1)) begin
                     frame_done <= 1'b1;
                     busy       <= 1'b0;
                     state_r    <= IDLE;
                  end else begin
                     row_r       <= row_r + 5'd1;
                     rom_address <= row_r + 5'd1;
                     state_r     <= FETCH;
                  end
               end else begin
                  state_r <= PRESENT;
               end
            end
            default: begin
               row_valid <= 1'b0;
               busy      <= 1'b0;
               state_r   <= IDLE;
            end
         endcase

         // Placed after the FSM so a request landing on a consume cycle re-arms pending.
         if (request_s) begin
            pending_r <= 1'b1;
            if (pending_r && !consume_s) begin
               overrun <= 1'b1;
            end
            if (tick_wrap_s) begin
               tick_cnt_r     <= '0;
               step_pending_r <= 1'b1;
            end else begin
               tick_cnt_r <= tick_cnt_r + TICK_W'(1);
            end
         end else if (consume_s) begin
            pending_r <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_banner_scroll_ctrl.sv
// Self-checking bench for banner_scroll_ctrl: random glyph ROM, random backpressure,
// expected rows computed from the column/window rules with plain arithmetic.
module tb_banner_scroll_ctrl;

   localparam int ROWS = 15;
   localparam int BW   = 71;
   localparam int WW   = 16;
   localparam int SDIV = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic          frame_tick;
   logic [4:0]    rom_address;
   logic [BW-1:0] rom_data;
   logic          row_valid;
   logic          row_ready;
   logic [4:0]    row_index;
   logic [WW-1:0] row_pixels;
   logic [6:0]    scroll_offset;
   logic          busy;
   logic          frame_done;
   logic          overrun;

   logic [BW-1:0] rom [0:ROWS-1];

   int checks   = 0;
   int failures = 0;

   logic [4:0]    got_idx[$];
   logic [WW-1:0] got_pix[$];
   logic [6:0]    got_off[$];

   banner_scroll_ctrl #(
      .ROWS(ROWS), .BANNER_W(BW), .WIN_W(WW), .SCROLL_DIV(SDIV)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .frame_tick(frame_tick),
      .rom_address(rom_address), .rom_data(rom_data),
      .row_valid(row_valid), .row_ready(row_ready), .row_index(row_index),
      .row_pixels(row_pixels), .scroll_offset(scroll_offset), .busy(busy),
      .frame_done(frame_done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Glyph ROM with one cycle of registered read latency.
   always @(posedge clk) rom_data <= rom[rom_address];

   // Window pixel j is banner column (off+j) mod BW, leftmost at the MSB.
   function automatic logic [WW-1:0] win(input int r, input int off);
      logic [WW-1:0] p;
      int col;
      for (int j = 0; j < WW; j++) begin
         col = (off + j) % BW;
         p[WW-1-j] = rom[r][BW-1-col];
      end
      return p;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; frame_tick = 1'b0; enable = 1'b1; row_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Records every row handshake until frame_done; done_edges counts clock edges
   // after the edge that registered the request (-1 when the budget runs out).
   task automatic collect_frame(input int ready_pct, input int tick_a, input int tick_b,
                                input int drop_en_at, output int done_edges);
      got_idx.delete(); got_pix.delete(); got_off.delete();
      done_edges = -1;
      for (int c = 1; c <= 3000; c++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         if (frame_done) begin
            done_edges = c - 1;
            break;
         end
         if (c == tick_a || c == tick_b) frame_tick = 1'b1;
         if (c == drop_en_at) enable = 1'b0;
         row_ready = (int'($urandom_range(0, 99)) < ready_pct);
         if (row_valid && row_ready) begin
            got_idx.push_back(row_index);
            got_pix.push_back(row_pixels);
            got_off.push_back(scroll_offset);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; row_ready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({rom_address, row_valid, row_index, row_pixels, scroll_offset, busy, frame_done, overrun}
          !== 37'd0) begin
         failures++;
         $display("FAIL reset_state addr=%0d valid=%b idx=%0d pix=%h off=%0d busy=%b done=%b ovr=%b expected all zero",
                  rom_address, row_valid, row_index, row_pixels, scroll_offset, busy, frame_done, overrun);
      end
      rst = 1'b0;
   endtask

   task automatic test_basic_frame();
      int de;
      do_reset();
      @(negedge clk); frame_tick = 1'b1;
      collect_frame(100, 0, 0, 0, de);
      checks++;
      if (de !== 46 || got_idx.size() != ROWS) begin
         failures++;
         $display("FAIL basic_timing done_edges=%0d rows=%0d expected 46 and %0d", de, got_idx.size(), ROWS);
      end
      for (int r = 0; r < got_idx.size(); r++) begin
         checks++;
         if (got_idx[r] !== 5'(r) || got_pix[r] !== win(r, 0) || got_off[r] !== 7'd0) begin
            failures++;
            $display("FAIL basic_row%0d idx=%0d pix=%h off=%0d expected idx=%0d pix=%h off=0",
                     r, got_idx[r], got_pix[r], got_off[r], r, win(r, 0));
         end
      end
      if (got_pix.size() == ROWS) begin
         checks++;
         if (got_pix[0] !== 16'h0000 || got_pix[3] !== 16'hC003 || got_pix[12] !== 16'hC003) begin
            failures++;
            $display("FAIL basic_glyph row0=%h row3=%h row12=%h expected 0000 c003 c003",
                     got_pix[0], got_pix[3], got_pix[12]);
         end
      end
      @(negedge clk);
      checks++;
      if (frame_done !== 1'b0 || busy !== 1'b0 || scroll_offset !== 7'd0) begin
         failures++;
         $display("FAIL basic_after done=%b busy=%b off=%0d expected 0 0 0", frame_done, busy, scroll_offset);
      end
   endtask

   task automatic test_scroll();
      int de;
      int exp_off;
      do_reset();
      for (int k = 1; k <= 284; k++) begin
         @(negedge clk); frame_tick = 1'b1;
         collect_frame(int'($urandom_range(70, 100)), 0, 0, 0, de);
         exp_off = (k / SDIV) % BW;
         checks++;
         if (de < 0 || got_idx.size() != ROWS) begin
            failures++;
            $display("FAIL scroll_frame%0d done_edges=%0d rows=%0d expected a finished frame of %0d rows",
                     k, de, got_idx.size(), ROWS);
         end
         for (int r = 0; r < got_idx.size(); r++) begin
            checks++;
            if (got_idx[r] !== 5'(r) || got_pix[r] !== win(r, exp_off) || got_off[r] !== 7'(exp_off)) begin
               failures++;
               $display("FAIL scroll_frame%0d_row%0d idx=%0d pix=%h off=%0d expected idx=%0d pix=%h off=%0d",
                        k, r, got_idx[r], got_pix[r], got_off[r], r, win(r, exp_off), exp_off);
            end
         end
         if (k == 280 && got_pix.size() == ROWS) begin
            checks++;
            if (got_pix[3] !== 16'h6001) begin
               failures++;
               $display("FAIL scroll_wrap_row3 pix=%h expected 6001", got_pix[3]);
            end
         end
      end
      checks++;
      if (overrun !== 1'b0) begin
         failures++;
         $display("FAIL scroll_no_overrun overrun=%b expected 0", overrun);
      end
   endtask

   task automatic test_backpressure();
      int hold = 0, accepted = 0, nhs = 0;
      bit done = 1'b0;
      logic [WW-1:0] sv_pix;
      logic [4:0]    sv_addr;
      do_reset();
      @(negedge clk); frame_tick = 1'b1;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         if (accepted == 1) begin
            checks++;
            if (row_valid !== 1'b0) begin
               failures++;
               $display("FAIL bp_release valid=%b expected 0 after handshake", row_valid);
            end
            accepted = 2;
         end
         if (frame_done) begin
            done = 1'b1;
            break;
         end
         if (row_valid && row_index == 5'd6 && hold < 5) begin
            if (hold == 0) begin
               sv_pix  = row_pixels;
               sv_addr = rom_address;
            end else begin
               checks++;
               if (row_valid !== 1'b1 || row_index !== 5'd6 || row_pixels !== sv_pix || rom_address !== sv_addr) begin
                  failures++;
                  $display("FAIL bp_hold%0d valid=%b idx=%0d pix=%h addr=%0d expected 1 6 %h %0d",
                           hold, row_valid, row_index, row_pixels, rom_address, sv_pix, sv_addr);
               end
            end
            row_ready = 1'b0;
            hold++;
         end else begin
            row_ready = 1'b1;
            if (row_valid) begin
               nhs++;
               if (row_index == 5'd6 && accepted == 0) begin
                  accepted = 1;
                  checks++;
                  if (row_pixels !== win(6, 0) || rom_address !== 5'd6) begin
                     failures++;
                     $display("FAIL bp_accept pix=%h addr=%0d expected %h 6", row_pixels, rom_address, win(6, 0));
                  end
               end
            end
         end
      end
      checks++;
      if (!done || nhs != ROWS || hold != 5) begin
         failures++;
         $display("FAIL bp_frame done=%b handshakes=%0d hold=%0d expected 1 %0d 5", done, nhs, hold, ROWS);
      end
   endtask

   task automatic test_overrun();
      int de;
      int busy_cycles = 0;
      do_reset();
      @(negedge clk); frame_tick = 1'b1;
      collect_frame(int'($urandom_range(50, 100)), 10, 20, 0, de);
      checks++;
      if (overrun !== 1'b1 || got_idx.size() != ROWS) begin
         failures++;
         $display("FAIL ovr_set overrun=%b rows=%0d expected 1 %0d", overrun, got_idx.size(), ROWS);
      end
      collect_frame(100, 0, 0, 0, de);
      checks++;
      if (de !== 45 || got_idx.size() != ROWS) begin
         failures++;
         $display("FAIL ovr_extra_frame done_edges=%0d rows=%0d expected 45 %0d", de, got_idx.size(), ROWS);
      end
      repeat (60) begin
         @(negedge clk);
         if (busy) busy_cycles++;
      end
      checks++;
      if (busy_cycles != 0 || overrun !== 1'b1) begin
         failures++;
         $display("FAIL ovr_single_extra busy_cycles=%0d overrun=%b expected 0 1", busy_cycles, overrun);
      end
   endtask

   task automatic test_back_to_back();
      int de;
      int busy_cycles = 0;
      do_reset();
      @(negedge clk); frame_tick = 1'b1;
      collect_frame(100, 10, 0, 0, de);
      checks++;
      if (de !== 46 || got_idx.size() != ROWS) begin
         failures++;
         $display("FAIL b2b_frame1 done_edges=%0d rows=%0d expected 46 %0d", de, got_idx.size(), ROWS);
      end
      // This request coincides with the IDLE cycle that consumes the pending one.
      frame_tick = 1'b1;
      for (int f = 2; f <= 3; f++) begin
         collect_frame(100, 0, 0, 0, de);
         checks++;
         if (de !== 45 || got_idx.size() != ROWS) begin
            failures++;
            $display("FAIL b2b_frame%0d done_edges=%0d rows=%0d expected 45 %0d", f, de, got_idx.size(), ROWS);
         end
         for (int r = 0; r < got_idx.size(); r++) begin
            checks++;
            if (got_idx[r] !== 5'(r) || got_pix[r] !== win(r, 0)) begin
               failures++;
               $display("FAIL b2b_frame%0d_row%0d idx=%0d pix=%h expected %0d %h", f, r, got_idx[r], got_pix[r], r, win(r, 0));
            end
         end
      end
      repeat (60) begin
         @(negedge clk);
         if (busy) busy_cycles++;
      end
      checks++;
      if (busy_cycles != 0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL b2b_idle busy_cycles=%0d overrun=%b expected 0 0", busy_cycles, overrun);
      end
   endtask

   task automatic test_reset_mid_frame();
      int de;
      int busy_cycles = 0;
      bit found = 1'b0;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk); frame_tick = 1'b1;
         collect_frame(100, 0, 0, 0, de);
      end
      @(negedge clk); frame_tick = 1'b1;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         row_ready = 1'($urandom_range(0, 1));
         if (row_valid && row_index == 5'd8) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      if (!found || scroll_offset !== 7'd1) begin
         failures++;
         $display("FAIL rstmid_reach found=%b off=%0d expected 1 1", found, scroll_offset);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; row_ready = 1'b1;
      checks++;
      if (row_valid !== 1'b0 || busy !== 1'b0 || scroll_offset !== 7'd0 || row_index !== 5'd0 ||
          rom_address !== 5'd0 || row_pixels !== 16'h0000 || frame_done !== 1'b0) begin
         failures++;
         $display("FAIL rstmid_state valid=%b busy=%b off=%0d idx=%0d addr=%0d pix=%h done=%b expected all zero",
                  row_valid, busy, scroll_offset, row_index, rom_address, row_pixels, frame_done);
      end
      repeat (10) begin
         @(negedge clk);
         if (busy) busy_cycles++;
      end
      frame_tick = 1'b1;
      collect_frame(100, 0, 0, 0, de);
      checks++;
      if (busy_cycles != 0 || de !== 46 || got_idx.size() != ROWS) begin
         failures++;
         $display("FAIL rstmid_restart busy_cycles=%0d done_edges=%0d rows=%0d expected 0 46 %0d",
                  busy_cycles, de, got_idx.size(), ROWS);
      end
      for (int r = 0; r < got_idx.size(); r++) begin
         checks++;
         if (got_idx[r] !== 5'(r) || got_pix[r] !== win(r, 0) || got_off[r] !== 7'd0) begin
            failures++;
            $display("FAIL rstmid_row%0d idx=%0d pix=%h off=%0d expected %0d %h 0",
                     r, got_idx[r], got_pix[r], got_off[r], r, win(r, 0));
         end
      end
   endtask

   task automatic test_enable();
      int de;
      int exp_off;
      int busy_cycles = 0;
      do_reset();
      enable = 1'b0;
      // Three ticks while disabled: a counter that wrongly counted them would shift the step.
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         frame_tick = (c % 9 == 4);
         if (busy || row_valid) busy_cycles++;
      end
      @(negedge clk);
      frame_tick = 1'b0;
      checks++;
      if (busy_cycles != 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL en_blocked busy_cycles=%0d expected 0", busy_cycles);
      end
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk); enable = 1'b1; frame_tick = 1'b1;
         collect_frame(int'($urandom_range(60, 100)), 0, 0, (k == 5) ? 10 : 0, de);
         exp_off = k / SDIV;
         checks++;
         if (de < 0 || got_idx.size() != ROWS) begin
            failures++;
            $display("FAIL en_frame%0d done_edges=%0d rows=%0d expected finished %0d rows", k, de, got_idx.size(), ROWS);
         end
         for (int r = 0; r < got_idx.size(); r++) begin
            checks++;
            if (got_idx[r] !== 5'(r) || got_pix[r] !== win(r, exp_off) || got_off[r] !== 7'(exp_off)) begin
               failures++;
               $display("FAIL en_frame%0d_row%0d idx=%0d pix=%h off=%0d expected %0d %h %0d",
                        k, r, got_idx[r], got_pix[r], got_off[r], r, win(r, exp_off), exp_off);
            end
         end
      end
      checks++;
      if (enable !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL en_drop_complete enable=%b busy=%b expected 0 0", enable, busy);
      end
   endtask

   initial begin
      logic [95:0] tmp;
      for (int r = 0; r < ROWS; r++) begin
         tmp = {$urandom, $urandom, $urandom};
         rom[r] = tmp[BW-1:0];
      end
      rom[0] = '0;
      tmp = '0;
      tmp[BW-1-0]  = 1'b1;
      tmp[BW-1-1]  = 1'b1;
      tmp[BW-1-14] = 1'b1;
      tmp[BW-1-15] = 1'b1;
      rom[3]  = tmp[BW-1:0];
      rom[12] = tmp[BW-1:0];

      test_reset();
      test_basic_frame();
      test_scroll();
      test_backpressure();
      test_overrun();
      test_back_to_back();
      test_reset_mid_frame();
      test_enable();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/banner_scroll_ctrl.md
Name: banner_scroll_ctrl

Overview:
Sequencer for the 15-row × 71-column banner glyph ROM (one-cycle registered address latency). On each frame request it fetches every ROM row in order and extracts a WIN_W-column window at the current horizontal scroll offset, with wrap-around. Each windowed row is presented to the display framebuffer writer over a valid/ready handshake. The scroll offset advances once every SCROLL_DIV frame ticks. The block sits between the frame-timing generator and the LED-matrix framebuffer.

Parameters:
ROWS, 15, number of ROM rows fetched per frame (addresses 0..ROWS-1)
BANNER_W, 71, ROM word width = banner length in columns
WIN_W, 16, visible window width in columns
SCROLL_DIV, 4, frame ticks per one-column scroll step (≥1)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
enable  in  1  level; frame requests are accepted only while high
frame_tick  in  1  one-cycle pulse; requests a frame and counts toward a scroll step
rom_address  out  5  registered address to the banner ROM
rom_data  in  BANNER_W  ROM output; valid one cycle after rom_address is registered into the ROM
row_valid  out  1  row_index/row_pixels valid
row_ready  in  1  framebuffer accepts the row
row_index  out  5  row number being presented
row_pixels  out  WIN_W  windowed row; MSB = leftmost visible column
scroll_offset  out  7  current leftmost banner column, range 0..BANNER_W-1
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse after the last row's handshake
overrun  out  1  sticky; set when a request arrives while one is already pending

Behaviour:
- Reset, including mid-frame: state=IDLE. All of these clear to 0: rom_address, row_valid, row_index, row_pixels, scroll_offset, busy, frame_done, overrun, the pending flag and the tick counter. Any row in flight is discarded.
- Column convention: banner column c is rom_data[BANNER_W-1-c]. Window pixel j (j=0..WIN_W-1) = column (scroll_offset+j) mod BANNER_W, placed at row_pixels[WIN_W-1-j].
- Request: the cycle with enable=1 and frame_tick=1 sets pending.
  - If pending is already set and the FSM has not yet consumed it, set overrun.
  - A request in the same cycle as a consume re-sets pending with no overrun.
- Tick counter (0..SCROLL_DIV-1): increments on every frame_tick while enable=1. On wrap it sets step_pending.
- step_pending is applied only in IDLE, just before a frame starts: scroll_offset ← (scroll_offset+1) mod BANNER_W, so 70→0. The offset never changes mid-frame.
- FSM:
  - IDLE: if pending → clear pending, apply step_pending, row←0, rom_address←0 → FETCH.
  - FETCH (1 cycle): the ROM registers the address → CAPTURE.
  - CAPTURE (1 cycle): row_pixels ← window(rom_data); row_index←row; row_valid←1 → PRESENT.
  - PRESENT: hold row_valid, row_index and row_pixels stable until row_valid&row_ready.
    - On handshake: row_valid←0.
    - If row=ROWS-1: frame_done←1 (one cycle) → IDLE.
    - Else: row←row+1, rom_address←row+1 → FETCH.
- Minimum cost is 3 cycles per row with row_ready tied high, so 45 cycles + 1 IDLE cycle per frame.
- rom_address is held constant from FETCH through PRESENT.
- enable=0 does not abort a frame in progress. It only blocks new requests and tick counting.
- frame_done and a new IDLE start can occur in back-to-back cycles. A request pending at frame end starts the next frame immediately.

Test Plan:
- Reset, enable=1, one frame_tick, row_ready=1 → rows 0..14 presented in order. Row 0 row_pixels=16'h0000, row 3=16'hC003, row 12=16'hC003. frame_done pulses once, 46 cycles after the request. scroll_offset stays 0.
- SCROLL_DIV=4: run 4 frames → the 4th tick's frame starts with scroll_offset=1. Preload to offset 70 (280 ticks) → row 3 row_pixels=16'h6001 (wrap: column 70=0, then columns 0..14). The next step gives offset 0.
- Backpressure: hold row_ready=0 for 5 cycles on row 6 → row_valid, row_index=6 and row_pixels stay constant. No ROM address change. The row is accepted on the first ready cycle.
- Two frame_ticks during one frame → overrun=1. The second tick yields exactly one extra frame after frame_done.
- Assert rst during PRESENT of row 8 → next cycle: IDLE, row_valid=0, scroll_offset=0, busy=0. A new tick restarts from row 0.
- enable=0 with frame_ticks → no frames, tick counter frozen. Dropping enable mid-frame → the current frame completes through row 14.
